// File: rtl/multicycle_ex_ctrl.sv
// Multi-cycle EX stage controller: sequences integer DIV/REM and FP FDIV/FSQRT
// ops, stalls the pipeline while they run, captures the result and aborts a
// hung FPU operation after FPU_TIMEOUT cycles.
module multicycle_ex_ctrl #(
    parameter int DIV_LATENCY = 8,
    parameter int FPU_TIMEOUT = 63,
    parameter int CNT_W       = 6
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iEX_DivRem,
    input  logic        iEX_FPMulti,
    input  logic        iFlush,
    input  logic        iFPU_Ready,
    input  logic [31:0] iDiv_Result,
    input  logic [31:0] iFPU_Result,
    output logic        oStall,
    output logic        oDivStart,
    output logic        oFPUStart,
    output logic [31:0] oResult,
    output logic        oResultValid,
    output logic        oBusy,
    output logic        oTimeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        FP_RUN  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_LATENCY - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(FPU_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             cap;
    logic [31:0]      cap_val;
    logic             to_set;

    // State, counter, captured result and sticky timeout registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state    <= IDLE;
            cnt      <= '0;
            oResult  <= '0;
            oTimeout <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (cap)
                oResult <= cap_val;
            if (to_set)
                oTimeout <= 1'b1;
        end
    end

    // Next-state, counter and capture decisions plus combinational outputs
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cap          = 1'b0;
        cap_val      = oResult;
        to_set       = 1'b0;
        oStall       = 1'b0;
        oDivStart    = 1'b0;
        oFPUStart    = 1'b0;
        oResultValid = 1'b0;
        oBusy        = (state != IDLE);

        case (state)
            IDLE: begin
                // DIV/REM has priority over a simultaneous FP request
                if (iEX_DivRem && !iFlush) begin
                    state_nxt = DIV_RUN;
                    cnt_nxt   = '0;
                    oStall    = 1'b1;
                end else if (iEX_FPMulti && !iFlush) begin
                    state_nxt = FP_RUN;
                    cnt_nxt   = '0;
                    oStall    = 1'b1;
                end
            end
            DIV_RUN: begin
                oStall    = !iFlush;
                oDivStart = (cnt == CNT_ZERO);
                if (iFlush) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DIV_LAST) begin
                    cap       = 1'b1;
                    cap_val   = iDiv_Result;
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            FP_RUN: begin
                oStall    = !iFlush;
                oFPUStart = (cnt == CNT_ZERO);
                if (iFlush) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (iFPU_Ready) begin
                    // ready beats a timeout landing on the same cycle
                    cap       = 1'b1;
                    cap_val   = iFPU_Result;
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else if (cnt == TO_LAST) begin
                    cap       = 1'b1;
                    cap_val   = 32'h0000_0000;
                    to_set    = 1'b1;
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            DONE: begin
                // request inputs are deliberately ignored here; EX releases now
                oResultValid = !iFlush;
                state_nxt    = IDLE;
                cnt_nxt      = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // reset holds every handshake output quiet
        if (iRST) begin
            oStall       = 1'b0;
            oDivStart    = 1'b0;
            oFPUStart    = 1'b0;
            oResultValid = 1'b0;
            oBusy        = 1'b0;
        end
    end

endmodule
